baud_gen_frac: RTL

Fractional-N baud-rate tick generator for the UART and serial control paths. It is the parametrised successor of the fixed integer-divider baud generator. A phase accumulator produces an oversampling clock-enable whose average rate is exactly fCLK·freq/modulus, with no integer-division error. An internal oversample counter derives bit-rate and mid-bit strobes. Divider settings are runtime-programmable, with built-in validity checking and phase restart, so one instance serves every baud rate without resynthesis.

---
 rtl/baud_gen_frac.sv | 101 ++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-N baud tick generator with oversample, bit and mid-bit strobes
module baud_gen_frac #(
  parameter int          ACC_W    = 16,
  parameter int          OS_LOG2  = 4,
  parameter int unsigned DEF_FREQ = 576,
  parameter int unsigned DEF_MOD  = 15625
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_freq,
  input  logic [ACC_W-1:0] cfg_mod,
  output logic             ce_os,
  output logic             ce_bit,
  output logic             ce_mid,
  output logic             cfg_err
);

  localparam int OS = 1 << OS_LOG2;
  localparam logic [OS_LOG2-1:0] OS_LAST = OS_LOG2'(OS - 1);
  localparam logic [OS_LOG2-1:0] OS_MID  = OS_LOG2'(OS / 2 - 1);

  logic [ACC_W-1:0]   freq_q, freq_d;
  logic [ACC_W-1:0]   mod_q, mod_d;
  logic [ACC_W:0]     acc_q, acc_d;
  logic [OS_LOG2-1:0] os_cnt_q, os_cnt_d;
  logic               err_q, err_d;
  logic               ce_os_q, ce_bit_q, ce_mid_q;

  logic [ACC_W:0] sum;
  logic           hit;
  logic           tick;
  logic           cfg_valid;

  // acc stays below mod_r, and freq_r < mod_r, so the sum never exceeds ACC_W+1 bits
  assign sum       = acc_q + {1'b0, freq_q};
  assign hit       = (sum >= {1'b0, mod_q});
  assign cfg_valid = (cfg_freq != '0) && (cfg_freq < cfg_mod);

  always_comb begin
    freq_d   = freq_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    os_cnt_d = os_cnt_q;
    err_d    = err_q;
    tick     = 1'b0;
    if (cfg_we) begin
      err_d = ~cfg_valid;
      if (cfg_valid) begin
        freq_d = cfg_freq;
        mod_d  = cfg_mod;
      end
      // a coincident sync still restarts the phase even if the write is rejected
      if (cfg_valid || sync) begin
        acc_d    = '0;
        os_cnt_d = '0;
      end
    end else if (sync) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (enable) begin
      if (hit) begin
        acc_d    = sum - {1'b0, mod_q};
        tick     = 1'b1;
        os_cnt_d = os_cnt_q + 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freq_q   <= ACC_W'(DEF_FREQ);
      mod_q    <= ACC_W'(DEF_MOD);
      acc_q    <= '0;
      os_cnt_q <= '0;
      err_q    <= 1'b0;
      ce_os_q  <= 1'b0;
      ce_bit_q <= 1'b0;
      ce_mid_q <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      os_cnt_q <= os_cnt_d;
      err_q    <= err_d;
      ce_os_q  <= tick;
      ce_bit_q <= tick && (os_cnt_q == OS_LAST);
      ce_mid_q <= tick && (os_cnt_q == OS_MID);
    end
  end

  assign ce_os   = ce_os_q;
  assign ce_bit  = ce_bit_q;
  assign ce_mid  = ce_mid_q;
  assign cfg_err = err_q;

endmodule
